// File: rtl/dct_serial_pkg.sv
// Shared definitions for the bit-serial DCT datapath front end.
// Holds default operand geometry, the feeder FSM encoding and small helpers
// used to size frame counters from module parameters.
package dct_serial_pkg;

    localparam int unsigned DEF_W     = 8;
    localparam int unsigned DEF_GUARD = 1;
    localparam int unsigned L         = DEF_W + DEF_GUARD;
    localparam int unsigned CNT_W     = $clog2(L);

    // Feeder FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic int unsigned frame_len(input int unsigned w, input int unsigned guard);
        return w + guard;
    endfunction

    // A one-bit frame still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/serial_shift_lane.sv
// One operand lane of the serial feeder: parallel load, LSB-first right shift,
// and guard-bit extension.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset
//   load    - capture din into the shifter (wins over shift)
//   shift   - advance to the next bit
//   din     - parallel operand
//   bit_out - current serial bit (shifter LSB)
module serial_shift_lane
    import dct_serial_pkg::*;
#(
    parameter int unsigned W      = DEF_W,
    parameter int unsigned GUARD  = DEF_GUARD,
    parameter bit          SIGNED = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         bit_out
);

    // With no guard bits the fill value is never observed, so skip the sign flop use.
    localparam bit EXT_USED = SIGNED && (GUARD != 0);

    logic [W-1:0] sr;
    logic [W-1:0] sr_shifted;
    logic         ext;

    // The extension bit is shifted in at the top, so after W shifts the LSB
    // naturally presents the guard value without a bit-index mux.
    always_comb begin
        sr_shifted        = sr >> 1;
        sr_shifted[W-1]   = ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= '0;
            ext <= 1'b0;
        end else if (load) begin
            sr  <= din;
            ext <= EXT_USED ? din[W-1] : 1'b0;
        end else if (shift) begin
            sr  <= sr_shifted;
        end
    end

    assign bit_out = sr[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial front end for the bit-serial adder. Accepts operand pairs
// over valid/ready, emits each pair LSB-first as an L = W+GUARD bit frame with
// first_bit/last_bit markers. A one-entry holding register keeps frames gapless.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   in_valid / in_ready  - operand pair handshake
//   a_in, b_in           - parallel operands
//   a_bit, b_bit         - serial bits of the current frame
//   bit_valid            - a frame bit is presented this cycle
//   first_bit, last_bit  - frame index 0 / index L-1
//   busy                 - frame in flight or holding register occupied
module serial_operand_feeder
    import dct_serial_pkg::*;
#(
    parameter int unsigned W      = DEF_W,
    parameter int unsigned GUARD  = DEF_GUARD,
    parameter bit          SIGNED = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         a_bit,
    output logic         b_bit,
    output logic         bit_valid,
    output logic         first_bit,
    output logic         last_bit,
    output logic         busy
);

    localparam int unsigned FLEN = frame_len(W, GUARD);
    localparam int unsigned CW   = cnt_width(FLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FLEN - 1);

    logic [0:0]   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold_full_q, hold_full_d;
    logic [W-1:0]  hold_a_q, hold_b_q;

    logic          accept;
    logic          at_last;
    logic          hold_load;
    logic          load;
    logic          shift;
    logic [W-1:0]  load_a, load_b;
    logic          lane_a, lane_b;

    assign in_ready = !hold_full_q;
    assign accept   = in_valid && in_ready;
    assign at_last  = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        hold_load   = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        load_a      = a_in;
        load_b      = b_in;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                if (!at_last) begin
                    cnt_d = cnt_q + CW'(1);
                    shift = 1'b1;
                    if (accept) begin
                        hold_load   = 1'b1;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Held pair takes precedence; in_ready is low so no accept can collide.
                    load        = 1'b1;
                    load_a      = hold_a_q;
                    load_b      = hold_b_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    load  = 1'b1;
                    cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Payload only; validity is tracked by hold_full_q.
    always_ff @(posedge clk) begin
        if (hold_load) begin
            hold_a_q <= a_in;
            hold_b_q <= b_in;
        end
    end

    serial_shift_lane #(
        .W      (W),
        .GUARD  (GUARD),
        .SIGNED (SIGNED)
    ) u_lane_a (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .shift   (shift),
        .din     (load_a),
        .bit_out (lane_a)
    );

    serial_shift_lane #(
        .W      (W),
        .GUARD  (GUARD),
        .SIGNED (SIGNED)
    ) u_lane_b (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .shift   (shift),
        .din     (load_b),
        .bit_out (lane_b)
    );

    assign bit_valid = (state_q == ST_SHIFT);
    assign a_bit     = bit_valid && lane_a;
    assign b_bit     = bit_valid && lane_b;
    assign first_bit = bit_valid && (cnt_q == '0);
    assign last_bit  = bit_valid && at_last;
    assign busy      = bit_valid || hold_full_q;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder (W=8, GUARD=1): a signed and an unsigned
// instance share the same stimulus. Frames are reassembled, summed serially
// with the carry cleared on first_bit, and compared with arithmetic expectations.
module tb_serial_operand_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] a_in, b_in;

    logic in_ready, a_bit, b_bit, bit_valid, first_bit, last_bit, busy;
    logic u_in_ready, u_a_bit, u_b_bit, u_bit_valid, u_first_bit, u_last_bit, u_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int frames_done = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] fa_s;
        logic [8:0] fb_s;
        logic [8:0] fa_u;
        logic [8:0] fb_u;
    } vec_t;

    pair_t exp_q[$];

    serial_operand_feeder #(.W(8), .GUARD(1), .SIGNED(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .bit_valid (bit_valid),
        .first_bit (first_bit),
        .last_bit  (last_bit),
        .busy      (busy)
    );

    serial_operand_feeder #(.W(8), .GUARD(1), .SIGNED(1'b0)) dut_u (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (u_in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .a_bit     (u_a_bit),
        .b_bit     (u_b_bit),
        .bit_valid (u_bit_valid),
        .first_bit (u_first_bit),
        .last_bit  (u_last_bit),
        .busy      (u_busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame monitor: reassembles both instances' frames and a carry-cleared serial sum.
    int         idx = 0;
    logic [8:0] fa, fb, fua, fub, fsum;
    logic       carry;
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            idx = 0;
        end else begin
            if (bit_valid) begin
                if (first_bit) begin
                    idx = 0; carry = 1'b0;
                    fa = '0; fb = '0; fua = '0; fub = '0; fsum = '0;
                end
                if (idx < 9) begin
                    fa[idx]   = a_bit;
                    fb[idx]   = b_bit;
                    fua[idx]  = u_a_bit;
                    fub[idx]  = u_b_bit;
                    fsum[idx] = a_bit ^ b_bit ^ carry;
                end
                carry = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
                idx++;
                if (last_bit) begin
                    check("frame_len", idx, 9);
                    if (exp_q.size() == 0) begin
                        check("frame_unexpected", 1, 0);
                    end else begin
                        pair_t      p;
                        logic [8:0] ea, eb, ua, ub, es;
                        p  = exp_q.pop_front();
                        ea = {p.a[7], p.a};
                        eb = {p.b[7], p.b};
                        ua = {1'b0, p.a};
                        ub = {1'b0, p.b};
                        es = ea + eb;
                        check("frame_a_signed", fa, ea);
                        check("frame_b_signed", fb, eb);
                        check("frame_a_unsigned", fua, ua);
                        check("frame_b_unsigned", fub, ub);
                        check("serial_sum", fsum, es);
                    end
                    frames_done++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back({a_in, b_in});
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60) begin step(); n++; end
        check(name, busy, 0);
    endtask

    vec_t       tbl[6];
    logic [7:0] bb_a[3];
    logic [7:0] bb_b[3];

    initial begin
        tbl[0] = '{a: 8'h05, b: 8'h03, fa_s: 9'h005, fb_s: 9'h003, fa_u: 9'h005, fb_u: 9'h003};
        tbl[1] = '{a: 8'hF0, b: 8'h0F, fa_s: 9'h1F0, fb_s: 9'h00F, fa_u: 9'h0F0, fb_u: 9'h00F};
        tbl[2] = '{a: 8'h80, b: 8'h7F, fa_s: 9'h180, fb_s: 9'h07F, fa_u: 9'h080, fb_u: 9'h07F};
        tbl[3] = '{a: 8'hFF, b: 8'h01, fa_s: 9'h1FF, fb_s: 9'h001, fa_u: 9'h0FF, fb_u: 9'h001};
        tbl[4] = '{a: 8'h00, b: 8'hAA, fa_s: 9'h000, fb_s: 9'h1AA, fa_u: 9'h000, fb_u: 9'h0AA};
        tbl[5] = '{a: 8'h5A, b: 8'hC3, fa_s: 9'h05A, fb_s: 9'h1C3, fa_u: 9'h05A, fb_u: 9'h0C3};
        bb_a = '{8'h11, 8'h92, 8'h7E};
        bb_b = '{8'hE4, 8'h08, 8'h81};

        // Reset, with an offered pair that reset must override
        reset = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0;
        step(); step();
        in_valid = 1'b1; a_in = 8'h12; b_in = 8'h34;
        step();
        in_valid = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_first_last", {first_bit, last_bit}, 0);
        check("rst_bits", {a_bit, b_bit}, 0);
        reset = 1'b0;
        step();
        check("rst_idle_after", bit_valid, 0);

        // Table-driven single frames
        for (int t = 0; t < 6; t++) begin
            in_valid = 1'b1; a_in = tbl[t].a; b_in = tbl[t].b;
            step();
            in_valid = 1'b0;
            for (int i = 0; i < 9; i++) begin
                check("tbl_bit_valid", bit_valid, 1);
                check("tbl_a_bit", a_bit, tbl[t].fa_s[i]);
                check("tbl_b_bit", b_bit, tbl[t].fb_s[i]);
                check("tbl_ua_bit", u_a_bit, tbl[t].fa_u[i]);
                check("tbl_ub_bit", u_b_bit, tbl[t].fb_u[i]);
                check("tbl_first", first_bit, (i == 0));
                check("tbl_last", last_bit, (i == 8));
                step();
            end
            check("tbl_idle_valid", bit_valid, 0);
            check("tbl_idle_busy", busy, 0);
        end

        // Back-to-back: three pairs with in_valid held high
        begin
            int idx_bb = 0, nbv = 0, first_v = -1, last_v = -1;
            int fbs[$];
            logic acc;
            in_valid = 1'b1; a_in = bb_a[0]; b_in = bb_b[0];
            for (int c = 0; c < 40; c++) begin
                acc = in_valid && in_ready;
                step();
                if (acc) begin
                    idx_bb++;
                    if (idx_bb < 3) begin a_in = bb_a[idx_bb]; b_in = bb_b[idx_bb]; end
                    else in_valid = 1'b0;
                end
                if (c + 1 == 2) check("bb_ready_low", in_ready, 0);
                if (c + 1 == 10) check("bb_ready_back", in_ready, 1);
                if (bit_valid) begin
                    if (first_v < 0) first_v = c + 1;
                    last_v = c + 1;
                    nbv++;
                end
                if (first_bit) fbs.push_back(c + 1);
            end
            check("bb_valid_count", nbv, 27);
            check("bb_first_cycle", first_v, 1);
            check("bb_contiguous", last_v - first_v + 1, nbv);
            check("bb_first_marks", fbs.size(), 3);
            if (fbs.size() == 3) begin
                check("bb_first0", fbs[0], 1);
                check("bb_first1", fbs[1], 10);
                check("bb_first2", fbs[2], 19);
            end
        end

        // Reset during bit index 4, with a pair sitting in the holding register
        begin
            int stray = 0;
            in_valid = 1'b1; a_in = 8'h33; b_in = 8'hC4;
            step();
            a_in = 8'h44; b_in = 8'h55;
            step();
            in_valid = 1'b0;
            check("abort_hold_full", in_ready, 0);
            step(); step(); step();
            check("abort_mid_valid", bit_valid, 1);
            check("abort_mid_last", last_bit, 0);
            reset = 1'b1;
            step();
            check("abort_bit_valid", bit_valid, 0);
            check("abort_in_ready", in_ready, 1);
            check("abort_busy", busy, 0);
            check("abort_last", last_bit, 0);
            reset = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (bit_valid || last_bit) stray++;
                step();
            end
            check("abort_no_frame", stray, 0);
        end

        // Randomised pairs with random in_valid gaps
        begin
            int   n_acc = 0, target, n = 0;
            logic acc;
            target = frames_done + 1000;
            in_valid = ($urandom_range(0, 2) != 0);
            a_in = 8'($urandom); b_in = 8'($urandom);
            for (int c = 0; c < 30000 && n_acc < 1000; c++) begin
                acc = in_valid && in_ready;
                step();
                if (acc) n_acc++;
                if (acc || !in_valid) begin
                    in_valid = (n_acc < 1000) && ($urandom_range(0, 2) != 0);
                    a_in = 8'($urandom); b_in = 8'($urandom);
                end
            end
            in_valid = 1'b0;
            check("rand_accepted", n_acc, 1000);
            while (frames_done < target && n < 100) begin step(); n++; end
            check("rand_frames", frames_done, target);
            wait_idle("rand_idle");
            check("rand_queue_empty", exp_q.size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
